// File: rtl/atm_pkg.sv
// Shared types and defaults for the ATM session sequencer.
package atm_pkg;

    // Session phases, in the order a normal session walks through them.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AUTH   = 3'd1,
        S_CHECK  = 3'd2,
        S_MENU   = 3'd3,
        S_EXEC   = 3'd4,
        S_LOCKED = 3'd5,
        S_EJECT  = 3'd6
    } session_state_e;

    // Front-panel operation codes.
    typedef enum logic [1:0] {
        OP_QUERY    = 2'd0,
        OP_WITHDRAW = 2'd1,
        OP_DEPOSIT  = 2'd2,
        OP_EXIT     = 2'd3
    } op_code_e;

    localparam int DEFAULT_MAX_TRIES   = 3;
    localparam int DEFAULT_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/atm_session_timer.sv
// Inactivity timer: reloads to TIMEOUT_CYC-1 on load, counts down while run
// is high, and flags expire while running with the count at zero.
module atm_session_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Reload has priority; otherwise count down while running, holding at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD_VAL;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Expire does not depend on load, so the caller may derive load from it.
    assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card insertion, PIN attempts with per-card lockout,
// operation dispatch and balance arithmetic towards cardhandling.
//
// Handshakes: psw_valid and op_valid are single-cycle strobes with no ready;
// each is honoured only in the state that consumes it (AUTH / MENU) and
// ignored elsewhere. op_done, insufficient and eject are single-cycle strobes
// out; updated_balance is valid while op_done is high.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int card_width     = 3,
    parameter int password_width = 4,
    parameter int balance_width  = 20,
    parameter int users_num      = 8,
    parameter int MAX_TRIES      = DEFAULT_MAX_TRIES,
    parameter int TIMEOUT_CYC    = DEFAULT_TIMEOUT_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     card_in,
    input  logic [card_width-1:0]    card_number,
    input  logic                     psw_valid,
    input  logic                     wrong_psw,
    input  logic [balance_width-1:0] balance,
    input  logic                     op_valid,
    input  logic [1:0]               op_code,
    input  logic [balance_width-1:0] amount,
    output logic [balance_width-1:0] updated_balance,
    output logic                     op_done,
    output logic                     auth_ok,
    output logic                     card_locked,
    output logic                     insufficient,
    output logic                     eject,
    output logic [1:0]               tries_left,
    output logic [2:0]               state_dbg
);

    // The PIN itself never passes through this block; password_width only
    // takes part in the parameter sanity check below.
    if (password_width < 1 || MAX_TRIES < 1 || MAX_TRIES > 3 ||
        users_num < 2 || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("atm_session_ctrl: unsupported parameter set");
    end

    localparam logic [1:0]               TRIES_INIT = 2'(MAX_TRIES);
    localparam logic [card_width:0]      CARD_LIMIT = (card_width + 1)'(users_num);
    localparam logic [users_num-1:0]     USER_ONE   = users_num'(1);
    localparam logic [balance_width-1:0] BAL_MAX    = {balance_width{1'b1}};

    session_state_e           state_q, state_d;
    logic [card_width-1:0]    card_q, card_d;
    logic [users_num-1:0]     lock_q, lock_d;
    logic [1:0]               tries_q, tries_d;
    op_code_e                 op_q, op_d;
    logic [balance_width-1:0] amount_q, amount_d;
    logic [balance_width-1:0] upd_q, upd_d;
    logic                     op_done_q, op_done_d;
    logic                     insuf_q, insuf_d;
    logic                     eject_q, eject_d;

    logic                     card_ok;
    logic                     card_is_locked;
    logic [balance_width:0]   dep_sum;
    logic                     tmr_load;
    logic                     tmr_run;
    logic                     tmr_expire;

    // Card ids outside the user table are rejected; ids beyond the bitmap shift out to "not locked".
    assign card_ok        = {1'b0, card_number} < CARD_LIMIT;
    assign card_is_locked = |(lock_q & (USER_ONE << card_number));
    assign dep_sum        = {1'b0, balance} + {1'b0, amount_q};

    // Every psw_valid in AUTH and op_valid in MENU moves the FSM, so a state
    // change alone is enough to restart the inactivity window.
    assign tmr_run  = (state_q == S_AUTH) || (state_q == S_MENU);
    assign tmr_load = (state_d != state_q);

    atm_session_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .run   (tmr_run),
        .expire(tmr_expire)
    );

    // Session state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            card_q    <= '0;
            lock_q    <= '0;
            tries_q   <= TRIES_INIT;
            op_q      <= OP_QUERY;
            amount_q  <= '0;
            upd_q     <= '0;
            op_done_q <= 1'b0;
            insuf_q   <= 1'b0;
            eject_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            card_q    <= card_d;
            lock_q    <= lock_d;
            tries_q   <= tries_d;
            op_q      <= op_d;
            amount_q  <= amount_d;
            upd_q     <= upd_d;
            op_done_q <= op_done_d;
            insuf_q   <= insuf_d;
            eject_q   <= eject_d;
        end
    end

    // Next-state, lockout, arithmetic and strobe generation.
    always_comb begin
        state_d   = state_q;
        card_d    = card_q;
        lock_d    = lock_q;
        tries_d   = tries_q;
        op_d      = op_q;
        amount_d  = amount_q;
        upd_d     = upd_q;
        op_done_d = 1'b0;
        insuf_d   = 1'b0;
        eject_d   = 1'b0;

        if ((state_q != S_IDLE) && !card_in) begin
            // Card pulled: abandon the session, drop any pending result, keep locks.
            state_d = S_IDLE;
            tries_d = TRIES_INIT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (card_in) begin
                        card_d = card_number;
                        if (!card_ok) begin
                            state_d = S_EJECT;
                        end else if (card_is_locked) begin
                            state_d = S_LOCKED;
                        end else begin
                            state_d = S_AUTH;
                        end
                    end
                end
                S_AUTH: begin
                    if (psw_valid) begin
                        state_d = S_CHECK;
                    end else if (tmr_expire) begin
                        state_d = S_EJECT;
                    end
                end
                S_CHECK: begin
                    if (!wrong_psw) begin
                        state_d = S_MENU;
                        tries_d = TRIES_INIT;
                    end else if (tries_q <= 2'd1) begin
                        state_d = S_LOCKED;
                        tries_d = 2'd0;
                        lock_d  = lock_q | (USER_ONE << card_q);
                    end else begin
                        state_d = S_AUTH;
                        tries_d = tries_q - 2'd1;
                    end
                end
                S_MENU: begin
                    if (op_valid) begin
                        if (op_code_e'(op_code) == OP_EXIT) begin
                            state_d = S_EJECT;
                        end else begin
                            state_d  = S_EXEC;
                            op_d     = op_code_e'(op_code);
                            amount_d = amount;
                        end
                    end else if (tmr_expire) begin
                        state_d = S_EJECT;
                    end
                end
                S_EXEC: begin
                    state_d   = S_MENU;
                    op_done_d = 1'b1;
                    case (op_q)
                        OP_WITHDRAW: begin
                            if (amount_q <= balance) begin
                                upd_d = balance - amount_q;
                            end else begin
                                upd_d   = balance;
                                insuf_d = 1'b1;
                            end
                        end
                        OP_DEPOSIT: upd_d = dep_sum[balance_width] ? BAL_MAX : dep_sum[balance_width-1:0];
                        default:    upd_d = balance;
                    endcase
                end
                S_LOCKED, S_EJECT: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Single eject pulse on entry to EJECT, from whichever state led there.
        if ((state_d == S_EJECT) && (state_q != S_EJECT)) begin
            eject_d = 1'b1;
            tries_d = TRIES_INIT;
        end
    end

    // Level outputs decode straight from the state register.
    assign auth_ok         = (state_q == S_MENU) || (state_q == S_EXEC);
    assign card_locked     = (state_q == S_LOCKED) && card_in;
    assign tries_left      = tries_q;
    assign updated_balance = upd_q;
    assign op_done         = op_done_q;
    assign insufficient    = insuf_q;
    assign eject           = eject_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios plus randomized sessions,
// checked against a transaction-level model of the session rules.
module tb_atm_session_ctrl;

    localparam int CW = 4;
    localparam int BW = 20;
    localparam int UN = 8;
    localparam int MT = 3;
    localparam int TO = 1024;
    localparam longint MAXB = (longint'(1) << BW) - 1;

    logic          clk;
    logic          rst;
    logic          card_in;
    logic [CW-1:0] card_number;
    logic          psw_valid;
    logic          wrong_psw;
    logic [BW-1:0] balance;
    logic          op_valid;
    logic [1:0]    op_code;
    logic [BW-1:0] amount;
    logic [BW-1:0] updated_balance;
    logic          op_done;
    logic          auth_ok;
    logic          card_locked;
    logic          insufficient;
    logic          eject;
    logic [1:0]    tries_left;
    logic [2:0]    state_dbg;

    atm_session_ctrl #(
        .card_width    (CW),
        .password_width(4),
        .balance_width (BW),
        .users_num     (UN),
        .MAX_TRIES     (MT),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .card_in        (card_in),
        .card_number    (card_number),
        .psw_valid      (psw_valid),
        .wrong_psw      (wrong_psw),
        .balance        (balance),
        .op_valid       (op_valid),
        .op_code        (op_code),
        .amount         (amount),
        .updated_balance(updated_balance),
        .op_done        (op_done),
        .auth_ok        (auth_ok),
        .card_locked    (card_locked),
        .insufficient   (insufficient),
        .eject          (eject),
        .tries_left     (tries_left),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- model state and scoreboard ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    logic [BW:0]   exp_q[$];          // {insufficient, updated_balance}
    bit            model_lock[UN];
    logic [BW-1:0] acct[UN];
    int            model_tries;
    int            cur_card;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Result of one operation computed from the plain account rules.
    function automatic logic [BW:0] model_op(input int code, input logic [BW-1:0] b, input logic [BW-1:0] a);
        longint lb = b;
        longint la = a;
        longint r;
        bit ins = 1'b0;
        case (code)
            1: begin
                if (la <= lb) r = lb - la;
                else begin
                    r = lb;
                    ins = 1'b1;
                end
            end
            2: begin
                r = lb + la;
                if (r > MAXB) r = MAXB;
            end
            default: r = lb;
        endcase
        return {ins, r[BW-1:0]};
    endfunction

    // Every op_done must match the oldest outstanding expected result.
    always @(negedge clk) begin
        logic [BW:0] e;
        if (!rst && op_done) begin
            if (exp_q.size() == 0) begin
                check("op_done_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("updated_balance", updated_balance, e[BW-1:0]);
                check("insufficient", insufficient, e[BW]);
            end
        end else if (!rst && insufficient) begin
            check("insufficient_without_op_done", 32'd1, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic insert(input int card);
        card_number = CW'(card);
        card_in     = 1'b1;
        if (card < UN) balance = acct[card];
        @(posedge clk);
        #1;
        card_number = CW'($urandom_range(0, 15));   // must be ignored from here on
        @(negedge clk);
        cur_card    = card;
        model_tries = MT;
        if (card >= UN) begin
            check("bad_card_eject", eject, 1);
            check("bad_card_auth", auth_ok, 0);
        end else if (model_lock[card]) begin
            check("locked_on_insert", card_locked, 1);
            check("locked_insert_auth", auth_ok, 0);
        end else begin
            check("insert_locked", card_locked, 0);
            check("insert_auth", auth_ok, 0);
            check("insert_tries", tries_left, MT);
        end
    endtask

    task automatic remove();
        card_in = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        model_tries = MT;
        check("remove_auth", auth_ok, 0);
        check("remove_locked", card_locked, 0);
        check("remove_eject", eject, 0);
        check("remove_tries", tries_left, MT);
    endtask

    task automatic pin(input bit wrong);
        psw_valid = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
            op_valid = 1'b1;                          // not legal in AUTH
            op_code  = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
        psw_valid = 1'b0;
        op_valid  = 1'b0;
        wrong_psw = wrong;
        @(posedge clk);
        #1;
        wrong_psw = 1'b0;
        @(negedge clk);
        if (!wrong) begin
            model_tries = MT;
            check("pin_ok_auth", auth_ok, 1);
            check("pin_ok_tries", tries_left, MT);
        end else begin
            model_tries--;
            if (model_tries == 0) model_lock[cur_card] = 1'b1;
            check("pin_bad_auth", auth_ok, 0);
            check("pin_bad_tries", tries_left, 32'(model_tries));
            check("pin_bad_locked", card_locked, (model_tries == 0) ? 1 : 0);
        end
    endtask

    // PIN strobe where it is not legal (locked card, rejected card).
    task automatic stray_pin();
        psw_valid = 1'b1;
        @(posedge clk);
        #1;
        psw_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stray_pin_auth", auth_ok, 0);
        check("stray_pin_eject", eject, 0);
    endtask

    task automatic do_op(input int code, input logic [BW-1:0] amt);
        logic [BW:0] e;
        op_code  = 2'(code);
        amount   = amt;
        op_valid = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
            psw_valid = 1'b1;                         // not legal in MENU
            wrong_psw = 1'($urandom_range(0, 1));
        end
        if (code != 3) begin
            e = model_op(code, acct[cur_card], amt);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        psw_valid = 1'b0;
        wrong_psw = 1'b0;
        op_code   = 2'($urandom_range(0, 3));
        amount    = BW'($urandom);
        @(negedge clk);
        if (code == 3) begin
            check("exit_eject", eject, 1);
            check("exit_auth", auth_ok, 0);
            check("exit_tries", tries_left, MT);
        end else begin
            check("op_done_early", op_done, 0);
            check("exec_auth", auth_ok, 1);
            @(negedge clk);
            check("op_done_latency", op_done, 1);
            acct[cur_card] = e[BW-1:0];
            balance = acct[cur_card];
        end
    endtask

    task automatic op_remove(input int code, input logic [BW-1:0] amt);
        op_code  = 2'(code);
        amount   = amt;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        card_in  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        model_tries = MT;
        check("removed_no_op_done", op_done, 0);
        check("removed_auth", auth_ok, 0);
        check("removed_tries", tries_left, MT);
    endtask

    function automatic logic [BW-1:0] pick_amount();
        logic [BW-1:0] b = acct[cur_card];
        case ($urandom_range(0, 3))
            0:       return BW'($urandom_range(0, 1000));
            1:       return b;
            2:       return BW'($urandom);
            default: return BW'($urandom_range(0, 32'(b)));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        int  card;
        int  nops;
        int  first;
        int  pulses;
        bit  ok;
        bit  w;

        rst = 1'b1;  card_in = 1'b0;  card_number = '0;
        psw_valid = 1'b0;  wrong_psw = 1'b0;  op_valid = 1'b0;
        op_code = '0;  amount = '0;  balance = '0;
        cur_card = 0;  model_tries = MT;
        for (int i = 0; i < UN; i++) begin
            model_lock[i] = 1'b0;
            acct[i] = BW'($urandom);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_op_done", op_done, 0);
        check("rst_updated_balance", updated_balance, 0);
        check("rst_auth", auth_ok, 0);
        check("rst_locked", card_locked, 0);
        check("rst_insufficient", insufficient, 0);
        check("rst_eject", eject, 0);
        check("rst_tries", tries_left, MT);
        rst = 1'b0;
        @(negedge clk);

        // Card 2: refused withdraw, normal withdraw, query, exit.
        acct[2] = 20'd500;
        insert(2);
        pin(1'b0);
        do_op(1, 20'd600);
        do_op(1, 20'd100);
        do_op(0, 20'd77);
        do_op(3, 20'd0);
        remove();

        // Card 5: three wrong PINs lock it; reinsertion goes straight to locked.
        insert(5);
        pin(1'b1);
        pin(1'b1);
        pin(1'b1);
        remove();
        insert(5);
        stray_pin();
        remove();

        // Card 3: saturating deposit, then card pulled mid-operation.
        acct[3] = BW'(MAXB - 4);
        insert(3);
        pin(1'b0);
        do_op(2, 20'd10);
        op_remove(1, 20'd5);

        // Card 9 is outside the user table.
        insert(9);
        stray_pin();
        remove();

        // Inactivity in MENU ejects after exactly TO cycles.
        insert(4);
        pin(1'b0);
        first = -1;
        pulses = 0;
        for (int k = 1; k <= TO + 4; k++) begin
            @(negedge clk);
            if (eject) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        check("timeout_cycle", 32'(first), TO);
        check("timeout_eject_pulses", 32'(pulses), 1);
        check("timeout_auth", auth_ok, 0);
        remove();

        // Randomized sessions.
        for (int s = 0; s < 30; s++) begin
            card = ($urandom_range(0, 9) < 8) ? $urandom_range(0, UN - 1) : $urandom_range(UN, 15);
            insert(card);
            if (card >= UN || model_lock[card]) begin
                stray_pin();
                remove();
                continue;
            end
            ok = 1'b0;
            while (!ok && !model_lock[card]) begin
                w = ($urandom_range(0, 3) == 0);
                pin(w);
                ok = !w;
            end
            if (!ok) begin
                remove();
                continue;
            end
            nops = $urandom_range(1, 4);
            for (int n = 0; n < nops; n++) begin
                do_op($urandom_range(0, 2), pick_amount());
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            case ($urandom_range(0, 3))
                0: remove();
                1: op_remove($urandom_range(0, 2), pick_amount());
                default: begin
                    do_op(3, 20'd0);
                    remove();
                end
            endcase
        end

        // Reset during EXEC: outputs clear at once, locks forgotten, no op_done.
        card = 0;
        while (card < UN - 1 && model_lock[card]) card++;
        model_lock[card] = 1'b0;
        insert(card);
        pin(1'b0);
        op_code  = 2'd2;
        amount   = 20'd7;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < UN; i++) model_lock[i] = 1'b0;
        exp_q.delete();
        check("rst_exec_op_done", op_done, 0);
        check("rst_exec_updated_balance", updated_balance, 0);
        check("rst_exec_auth", auth_ok, 0);
        check("rst_exec_eject", eject, 0);
        check("rst_exec_insufficient", insufficient, 0);
        check("rst_exec_tries", tries_left, MT);
        card_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_op_done", op_done, 0);
        insert(5);
        check("unlocked_after_rst", card_locked, 0);
        pin(1'b0);
        do_op(0, 20'd1);
        do_op(3, 20'd0);
        remove();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
